// File: rtl/branch_resolve_unit.sv
// Early branch resolution for the ID stage: forwarded operand select, six MIPS
// branch conditions, target adder, registered resolve/flush and hazard stall tracking.
module branch_resolve_unit #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_valid,
    input  logic [2:0]        branch_op,
    input  logic [WIDTH-1:0]  read_data1,
    input  logic [WIDTH-1:0]  read_data2,
    input  logic [WIDTH-1:0]  fwd_ex_data,
    input  logic [WIDTH-1:0]  fwd_mem_data,
    input  logic [1:0]        fwd_sel1,
    input  logic [1:0]        fwd_sel2,
    input  logic              operand_ready,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] imm_offset,
    output logic              stall,
    output logic              resolve_valid,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_target,
    output logic              flush,
    output logic              comparator_result,
    output logic              hazard_err
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic               err_set;
    logic [WIDTH-1:0]   op1, op2;
    logic               equal_c, taken_c, accept;
    logic [ADDR_W-1:0]  target_c;

    // Select 11 falls back to the register file value, same as 00.
    always_comb begin
        unique case (fwd_sel1)
            2'b01:   op1 = fwd_ex_data;
            2'b10:   op1 = fwd_mem_data;
            default: op1 = read_data1;
        endcase
        unique case (fwd_sel2)
            2'b01:   op2 = fwd_ex_data;
            2'b10:   op2 = fwd_mem_data;
            default: op2 = read_data2;
        endcase
    end

    always_comb begin
        equal_c = (op1 == op2);
        taken_c = 1'b0;
        unique case (branch_op)
            3'b000:  taken_c = equal_c;
            3'b001:  taken_c = !equal_c;
            3'b010:  taken_c = op1[WIDTH-1] || (op1 == '0);
            3'b011:  taken_c = !op1[WIDTH-1] && (op1 != '0);
            3'b100:  taken_c = op1[WIDTH-1];
            3'b101:  taken_c = !op1[WIDTH-1];
            default: taken_c = 1'b0;
        endcase
    end

    assign target_c = pc_plus4 + (imm_offset << 2);
    assign stall    = branch_valid && !operand_ready;
    assign accept   = branch_valid && operand_ready;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        err_set       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (stall) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!branch_valid || operand_ready) begin
                    state_next    = S_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                    err_set = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next    = S_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Result fields hold between accepts; only the pulse outputs drop back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            wait_cnt          <= '0;
            hazard_err        <= 1'b0;
            resolve_valid     <= 1'b0;
            flush             <= 1'b0;
            branch_taken      <= 1'b0;
            branch_target     <= '0;
            comparator_result <= 1'b0;
        end else begin
            state         <= state_next;
            wait_cnt      <= wait_cnt_next;
            hazard_err    <= hazard_err || err_set;
            resolve_valid <= accept;
            flush         <= accept && taken_c;
            if (accept) begin
                branch_taken      <= taken_c;
                branch_target     <= target_c;
                comparator_result <= equal_c;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, stall/hazard
// sequences and a randomized run against a behavioural model.
module tb_branch_resolve_unit;

    localparam int MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_valid;
    logic [2:0]  branch_op;
    logic [31:0] read_data1, read_data2, fwd_ex_data, fwd_mem_data;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        operand_ready;
    logic [31:0] pc_plus4, imm_offset;
    logic        stall, resolve_valid, branch_taken, flush, comparator_result, hazard_err;
    logic [31:0] branch_target;

    int checks = 0;
    int fails  = 0;

    branch_resolve_unit #(.WIDTH(32), .ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .branch_valid(branch_valid), .branch_op(branch_op),
        .read_data1(read_data1), .read_data2(read_data2),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .operand_ready(operand_ready),
        .pc_plus4(pc_plus4), .imm_offset(imm_offset), .stall(stall),
        .resolve_valid(resolve_valid), .branch_taken(branch_taken),
        .branch_target(branch_target), .flush(flush),
        .comparator_result(comparator_result), .hazard_err(hazard_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rd1, rd2, fex, fmem;
        logic [1:0]  s1, s2;
        logic [31:0] pc, imm;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic        exp_eq;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [1:0] s1, input logic [1:0] s2,
                                input logic [31:0] fex, input logic [31:0] fmem,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic tk, input logic [31:0] tg, input logic eq);
        vec_t v;
        v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.s1 = s1; v.s2 = s2;
        v.fex = fex; v.fmem = fmem; v.pc = pc; v.imm = imm;
        v.exp_taken = tk; v.exp_target = tg; v.exp_eq = eq;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid, input logic ready);
        branch_valid  = valid;
        operand_ready = ready;
        branch_op     = v.op;
        read_data1    = v.rd1;
        read_data2    = v.rd2;
        fwd_ex_data   = v.fex;
        fwd_mem_data  = v.fmem;
        fwd_sel1      = v.s1;
        fwd_sel2      = v.s2;
        pc_plus4      = v.pc;
        imm_offset    = v.imm;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " resolve_valid"}, 32'(resolve_valid), 0);
        checkOutput({tag, " branch_taken"}, 32'(branch_taken), 0);
        checkOutput({tag, " branch_target"}, branch_target, 0);
        checkOutput({tag, " flush"}, 32'(flush), 0);
        checkOutput({tag, " comparator_result"}, 32'(comparator_result), 0);
        checkOutput({tag, " hazard_err"}, 32'(hazard_err), 0);
    endtask

    // Reference: branch rules expressed as signed integer comparisons.
    function automatic logic model_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_sel(input logic [1:0] s, input logic [31:0] rd,
                                              input logic [31:0] ex, input logic [31:0] mem);
        if (s == 2'd1) return ex;
        if (s == 2'd2) return mem;
        return rd;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t idle_v;
        logic        m_rv, m_fl, m_tk, m_eq, m_err;
        logic [31:0] m_tg, a, b;
        int          streak;

        vecs[0]  = mk(3'd0, 32'h4, 32'h4,   2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 1);
        vecs[1]  = mk(3'd1, 32'h4, 32'h204, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 0);
        vecs[2]  = mk(3'd0, 32'h4, 32'h204, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[3]  = mk(3'd2, 0, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 1);
        vecs[4]  = mk(3'd3, 0, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 1);
        vecs[5]  = mk(3'd4, 0, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 1);
        vecs[6]  = mk(3'd5, 0, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 1);
        vecs[7]  = mk(3'd2, 1, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[8]  = mk(3'd3, 1, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 0);
        vecs[9]  = mk(3'd4, 1, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[10] = mk(3'd5, 1, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 0);
        vecs[11] = mk(3'd2, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 0);
        vecs[12] = mk(3'd3, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[13] = mk(3'd4, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 1, 32'h10C, 0);
        vecs[14] = mk(3'd5, 32'hFFFF_FFFF, 0, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[15] = mk(3'd6, 5, 5, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 1);
        vecs[16] = mk(3'd7, 5, 6, 2'b00, 2'b00, 0, 0, 32'h100, 3, 0, 32'h10C, 0);
        vecs[17] = mk(3'd0, 1, 2, 2'b01, 2'b10, 7, 7, 32'h100, 3, 1, 32'h10C, 1);
        vecs[18] = mk(3'd0, 9, 9, 2'b11, 2'b11, 1, 2, 32'h100, 3, 1, 32'h10C, 1);
        vecs[19] = mk(3'd1, 7, 7, 2'b10, 2'b01, 8, 7, 32'h100, 3, 1, 32'h10C, 0);
        vecs[20] = mk(3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFC, 1, 1, 32'h0, 1);
        vecs[21] = mk(3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h100, 32'hFFFF_FFFF, 1, 32'hFC, 1);
        vecs[22] = mk(3'd0, 1, 2, 2'b00, 2'b00, 0, 0, 32'h1000, 32'h4000_0000, 0, 32'h1000, 0);

        idle_v = mk(3'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        reset = 1'b1;
        applyStimulus(idle_v, 1'b0, 1'b1);
        step();
        checkAllZero("reset");
        checkOutput("reset stall", 32'(stall), 0);
        reset = 1'b0;

        // Directed table, applied back to back
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], 1'b1, 1'b1);
            #1 checkOutput($sformatf("vec%0d stall", i), 32'(stall), 0);
            step();
            checkOutput($sformatf("vec%0d resolve_valid", i), 32'(resolve_valid), 1);
            checkOutput($sformatf("vec%0d branch_taken", i), 32'(branch_taken), 32'(vecs[i].exp_taken));
            checkOutput($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].exp_taken));
            checkOutput($sformatf("vec%0d branch_target", i), branch_target, vecs[i].exp_target);
            checkOutput($sformatf("vec%0d comparator_result", i), 32'(comparator_result), 32'(vecs[i].exp_eq));
        end

        // No accept: pulses drop, result fields hold the last vector
        applyStimulus(vecs[0], 1'b0, 1'b1);
        step();
        checkOutput("hold resolve_valid", 32'(resolve_valid), 0);
        checkOutput("hold flush", 32'(flush), 0);
        checkOutput("hold branch_taken", 32'(branch_taken), 0);
        checkOutput("hold branch_target", branch_target, 32'h1000);
        checkOutput("hold comparator_result", 32'(comparator_result), 0);

        // One cycle not ready, then ready
        applyStimulus(vecs[0], 1'b1, 1'b0);
        #1 checkOutput("wait1 stall", 32'(stall), 1);
        step();
        checkOutput("wait1 no resolve", 32'(resolve_valid), 0);
        operand_ready = 1'b1;
        #1 checkOutput("wait1 stall released", 32'(stall), 0);
        step();
        checkOutput("wait1 resolve_valid", 32'(resolve_valid), 1);
        checkOutput("wait1 branch_target", branch_target, 32'h10C);
        checkOutput("wait1 hazard_err", 32'(hazard_err), 0);

        // Not ready for three cycles trips the timeout; flag is sticky
        applyStimulus(vecs[1], 1'b1, 1'b0);
        step();
        step();
        checkOutput("timeout after 2", 32'(hazard_err), 0);
        step();
        checkOutput("timeout after 3", 32'(hazard_err), 1);
        checkOutput("timeout stall", 32'(stall), 1);
        checkOutput("timeout no resolve", 32'(resolve_valid), 0);
        branch_valid = 1'b0;
        step();
        checkOutput("drop no resolve", 32'(resolve_valid), 0);
        checkOutput("drop sticky", 32'(hazard_err), 1);
        applyStimulus(vecs[2], 1'b1, 1'b1);
        step();
        checkOutput("sticky accept resolve", 32'(resolve_valid), 1);
        checkOutput("sticky after accept", 32'(hazard_err), 1);
        reset = 1'b1;
        branch_valid = 1'b0;
        step();
        checkOutput("sticky cleared by reset", 32'(hazard_err), 0);
        reset = 1'b0;

        // Reset arriving while waiting on an operand
        applyStimulus(vecs[0], 1'b1, 1'b1);
        step();
        operand_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1 checkOutput("midwait stall under reset", 32'(stall), 1);
        step();
        checkAllZero("midwait reset");
        reset = 1'b0;
        step();
        step();
        checkOutput("midwait fsm restarted", 32'(hazard_err), 0);
        operand_ready = 1'b1;
        step();
        checkOutput("midwait later resolve", 32'(resolve_valid), 1);
        branch_valid = 1'b0;
        step();

        // Randomized run against the behavioural model
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_rv = 0; m_fl = 0; m_tk = 0; m_eq = 0; m_err = 0; m_tg = 0; streak = 0;
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 49) == 0);
            branch_valid  = ($urandom_range(0, 3) != 0);
            operand_ready = ($urandom_range(0, 9) < 6);
            branch_op     = 3'($urandom_range(0, 7));
            read_data1    = pick();
            read_data2    = ($urandom_range(0, 2) == 0) ? read_data1 : pick();
            fwd_ex_data   = pick();
            fwd_mem_data  = pick();
            fwd_sel1      = 2'($urandom_range(0, 3));
            fwd_sel2      = 2'($urandom_range(0, 3));
            pc_plus4      = $urandom;
            imm_offset    = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
            #1 checkOutput($sformatf("rnd%0d stall", c), 32'(stall), 32'(branch_valid && !operand_ready));

            a = model_sel(fwd_sel1, read_data1, fwd_ex_data, fwd_mem_data);
            b = model_sel(fwd_sel2, read_data2, fwd_ex_data, fwd_mem_data);
            if (reset) begin
                m_rv = 0; m_fl = 0; m_tk = 0; m_eq = 0; m_err = 0; m_tg = 0; streak = 0;
            end else begin
                m_rv = branch_valid && operand_ready;
                m_fl = m_rv && model_taken(branch_op, a, b);
                if (m_rv) begin
                    m_tk = model_taken(branch_op, a, b);
                    m_eq = (a == b);
                    m_tg = pc_plus4 + imm_offset * 4;
                end
                streak = (branch_valid && !operand_ready) ? streak + 1 : 0;
                if (streak >= MAX_WAIT + 1) m_err = 1;
            end
            step();
            checkOutput($sformatf("rnd%0d resolve_valid", c), 32'(resolve_valid), 32'(m_rv));
            checkOutput($sformatf("rnd%0d flush", c), 32'(flush), 32'(m_fl));
            checkOutput($sformatf("rnd%0d branch_taken", c), 32'(branch_taken), 32'(m_tk));
            checkOutput($sformatf("rnd%0d branch_target", c), branch_target, m_tg);
            checkOutput($sformatf("rnd%0d comparator_result", c), 32'(comparator_result), 32'(m_eq));
            checkOutput($sformatf("rnd%0d hazard_err", c), 32'(hazard_err), 32'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
